// File: rtl/b16_spill_stack.sv
// rtl/b16_spill_stack.sv - circular on-chip stack with automatic spill/fill to a memory backing store
//
// Purpose:
//   Holds the top 2^DEP words of a cpu stack on chip. When occupancy reaches HI the
//   bottom entry is spilled to memory; when it drops to LO and memory holds words, the
//   most recently spilled word is filled back. The core is stalled during a transfer.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   push, pop, din      core stack operations (sampled only while stall is low)
//   dout                current top entry (entry at head-1)
//   count               on-chip occupancy, 0..2^DEP
//   mcount              words held in the backing store
//   stall               transfer in progress, core must hold push/pop
//   ovf, unf            sticky overflow / underflow flags
//   base_we, base_in    backing-store base load (IDLE only), clears mcount
//   en                  allows new transfers to start
//   maddr, mreq, mwr,
//   mdout, mdin, mack   memory bus: request held until acknowledge

module b16_spill_stack #(
   parameter int L   = 16,
   parameter int DEP = 4,
   parameter int HI  = 12,
   parameter int LO  = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push,
   input  logic           pop,
   input  logic [L-1:0]   din,
   output logic [L-1:0]   dout,
   output logic [DEP:0]   count,
   output logic [L-1:0]   mcount,
   output logic           stall,
   output logic           ovf,
   output logic           unf,
   input  logic           base_we,
   input  logic [L-1:0]   base_in,
   input  logic           en,
   output logic [L-1:0]   maddr,
   output logic           mreq,
   output logic           mwr,
   output logic [L-1:0]   mdout,
   input  logic [L-1:0]   mdin,
   input  logic           mack
);

   localparam int N = 1 << DEP;
   localparam logic [DEP:0] FULL = (DEP+1)'(N);
   localparam logic [DEP:0] HI_C = (DEP+1)'(HI);
   localparam logic [DEP:0] LO_C = (DEP+1)'(LO);

   typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

   state_t         state, state_nx;
   logic [L-1:0]   mem [N];
   logic [DEP-1:0] head, tail, head_nx, top_idx, core_waddr;
   logic [DEP:0]   cnt, cnt_nx;
   logic [L-1:0]   mcnt, mcnt_upd, base, base_upd;
   logic [L-1:0]   maddr_r, mdout_r;
   logic           mwr_r, ovf_r, unf_r;
   logic           core_we, ovf_set, unf_set;
   logic           base_lsb_unused;

   assign base_lsb_unused = base_in[0];
   assign top_idx = head - 1'b1;

   // Core-side update, only effective in IDLE (stall low).
   always_comb begin
      core_we    = 1'b0;
      core_waddr = head;
      head_nx    = head;
      cnt_nx     = cnt;
      ovf_set    = 1'b0;
      unf_set    = 1'b0;
      base_upd   = base;
      mcnt_upd   = mcnt;
      if (state == IDLE) begin
         // push+pop on an empty stack has no top to overwrite, so it acts as a push
         if (push && (!pop || cnt == '0)) begin
            if (cnt == FULL) begin
               ovf_set = 1'b1;
            end else begin
               core_we = 1'b1;
               head_nx = head + 1'b1;
               cnt_nx  = cnt + 1'b1;
            end
         end else if (pop && !push) begin
            if (cnt == '0) begin
               unf_set = (mcnt == '0);
            end else begin
               head_nx = head - 1'b1;
               cnt_nx  = cnt - 1'b1;
            end
         end else if (push && pop) begin
            core_we    = 1'b1;
            core_waddr = top_idx;
         end
         if (base_we) begin
            base_upd = {base_in[L-1:1], 1'b0};
            mcnt_upd = '0;
         end
      end
   end

   // Transfer decision uses the post-update occupancy so a push reaching HI starts a spill at once.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (en && cnt_nx >= HI_C)
               state_nx = SPILL;
            else if (en && cnt_nx <= LO_C && mcnt_upd != '0)
               state_nx = FILL;
         end
         SPILL, FILL: begin
            if (mack)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         head    <= '0;
         tail    <= '0;
         cnt     <= '0;
         mcnt    <= '0;
         base    <= '0;
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
         mwr_r   <= 1'b0;
         maddr_r <= '0;
         mdout_r <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               head  <= head_nx;
               cnt   <= cnt_nx;
               base  <= base_upd;
               mcnt  <= mcnt_upd;
               ovf_r <= ovf_r | ovf_set;
               unf_r <= unf_r | unf_set;
               if (state_nx == SPILL) begin
                  mdout_r <= mem[tail];
                  maddr_r <= base_upd + (mcnt_upd << 1);
                  mwr_r   <= 1'b1;
               end else if (state_nx == FILL) begin
                  maddr_r <= base_upd + ((mcnt_upd - 1'b1) << 1);
                  mwr_r   <= 1'b0;
               end
            end
            SPILL: begin
               if (mack) begin
                  tail <= tail + 1'b1;
                  cnt  <= cnt - 1'b1;
                  mcnt <= mcnt + 1'b1;
               end
            end
            FILL: begin
               if (mack) begin
                  tail <= tail - 1'b1;
                  cnt  <= cnt + 1'b1;
                  mcnt <= mcnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Entry storage is not reset; core writes and fill writes never coincide.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (core_we)
            mem[core_waddr] <= din;
         else if (state == FILL && mack)
            mem[tail - 1'b1] <= mdin;
      end
   end

   assign dout   = mem[top_idx];
   assign count  = cnt;
   assign mcount = mcnt;
   assign stall  = (state != IDLE);
   assign mreq   = (state != IDLE);
   assign mwr    = mwr_r;
   assign maddr  = maddr_r;
   assign mdout  = mdout_r;
   assign ovf    = ovf_r;
   assign unf    = unf_r;

endmodule

// File: tb/tb_b16_spill_stack.sv
// tb/tb_b16_spill_stack.sv - self-checking bench for b16_spill_stack with a queue-level reference model
module tb_b16_spill_stack;
   localparam int L = 16, DEP = 2, HI = 3, LO = 1, N = 4;

   logic clk = 1'b0, reset = 1'b1, push = 1'b0, pop = 1'b0;
   logic base_we = 1'b0, en = 1'b0, mack = 1'b0;
   logic [L-1:0] din = '0, base_in = '0, mdin = '0;
   logic [L-1:0] dout, mcount, maddr, mdout;
   logic [DEP:0] count;
   logic stall, ovf, unf, mreq, mwr;

   b16_spill_stack #(.L(L), .DEP(DEP), .HI(HI), .LO(LO)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .dout(dout),
      .count(count), .mcount(mcount), .stall(stall), .ovf(ovf), .unf(unf),
      .base_we(base_we), .base_in(base_in), .en(en), .maddr(maddr), .mreq(mreq),
      .mwr(mwr), .mdout(mdout), .mdin(mdin), .mack(mack)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: on-chip stack as a queue (index 0 = bottom), backing store as a queue
   // where element i lives at base + 2*i.
   logic [L-1:0] q[$];
   logic [L-1:0] bs[$];
   logic [L-1:0] m_base, m_addr, m_data;
   bit m_ovf, m_unf, started = 0;
   int m_phase = 0;   // 0 idle, 1 spill, 2 fill

   always @(posedge clk) begin
      if (reset) begin
         q.delete(); bs.delete();
         m_base = '0; m_ovf = 0; m_unf = 0; m_phase = 0;
         started = 1;
      end else if (m_phase == 0) begin
         if (push && (!pop || q.size() == 0)) begin
            if (q.size() == N) m_ovf = 1;
            else q.push_back(din);
         end else if (pop && !push) begin
            if (q.size() == 0) begin
               if (bs.size() == 0) m_unf = 1;
            end else begin
               void'(q.pop_back());
            end
         end else if (push && pop) begin
            q[q.size()-1] = din;
         end
         if (base_we) begin
            m_base = base_in & 16'hFFFE;
            bs.delete();
         end
         if (en && q.size() >= HI) begin
            m_phase = 1;
            m_addr  = m_base + 16'(2 * bs.size());
            m_data  = q[0];
         end else if (en && q.size() <= LO && bs.size() > 0) begin
            m_phase = 2;
            m_addr  = m_base + 16'(2 * (bs.size() - 1));
         end
      end else if (mack) begin
         if (m_phase == 1) bs.push_back(q.pop_front());
         else q.push_front(bs.pop_back());
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("count", 32'(count), q.size());
         chk("mcount", 32'(mcount), bs.size());
         chk("stall", 32'(stall), 32'(m_phase != 0));
         chk("mreq", 32'(mreq), 32'(m_phase != 0));
         chk("ovf", 32'(ovf), 32'(m_ovf));
         chk("unf", 32'(unf), 32'(m_unf));
         if (q.size() > 0) chk("dout", 32'(dout), 32'(q[q.size()-1]));
         if (m_phase != 0) begin
            chk("maddr", 32'(maddr), 32'(m_addr));
            chk("mwr", 32'(mwr), 32'(m_phase == 1));
         end
         if (m_phase == 1) chk("mdout", 32'(mdout), 32'(m_data));
      end
   end

   // Memory responder: acknowledges in the second cycle of each request.
   logic [L-1:0] bmem [int];
   bit auto_ack = 1;
   int wcnt = 0;

   always @(posedge clk) begin
      #1;
      if (auto_ack) begin
         if (!mreq) begin
            mack = 1'b0;
            wcnt = 0;
         end else if (!mack) begin
            wcnt++;
            if (wcnt == 2) begin
               mack = 1'b1;
               if (mwr) begin
                  bmem[int'(maddr)] = mdout;
                  mdin = 16'hDEAD;
               end else begin
                  mdin = bmem.exists(int'(maddr)) ? bmem[int'(maddr)] : 16'h0000;
               end
            end
         end
      end
   end

   task automatic step(input logic p, input logic po, input logic [L-1:0] d);
      push = p; pop = po; din = d;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (stall && k < budget) begin
         step(1'b0, 1'b0, '0);
         k++;
      end
      if (stall) begin
         n_checks++; n_fail++;
         $display("FAIL wait_idle: stall still %b after %0d cycles", stall, budget);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_count", 32'(count), 0);
      chk("rst_mcount", 32'(mcount), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_mreq", 32'(mreq), 0);
      chk("rst_mwr", 32'(mwr), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_unf", 32'(unf), 0);

      // spill after three pushes
      en = 1'b1; base_we = 1'b1; base_in = 16'h1001;
      step(1'b0, 1'b0, '0);
      base_we = 1'b0;
      step(1'b1, 1'b0, 16'h00A1);
      step(1'b1, 1'b0, 16'h00A2);
      step(1'b1, 1'b0, 16'h00A3);
      chk("sp_count", 32'(count), 3);
      chk("sp_mreq", 32'(mreq), 1);
      chk("sp_mwr", 32'(mwr), 1);
      chk("sp_maddr", 32'(maddr), 32'h1000);
      chk("sp_mdout", 32'(mdout), 32'h00A1);
      wait_idle(20);
      chk("sp_done_count", 32'(count), 2);
      chk("sp_done_mcount", 32'(mcount), 1);
      chk("sp_done_dout", 32'(dout), 32'h00A3);

      // pop twice with transfers disabled, then fill
      en = 1'b0;
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b1, '0);
      chk("pop2_count", 32'(count), 0);
      en = 1'b1;
      step(1'b0, 1'b0, '0);
      chk("fill_mreq", 32'(mreq), 1);
      chk("fill_mwr", 32'(mwr), 0);
      chk("fill_maddr", 32'(maddr), 32'h1000);
      wait_idle(20);
      chk("fill_count", 32'(count), 1);
      chk("fill_mcount", 32'(mcount), 0);
      chk("fill_dout", 32'(dout), 32'h00A1);

      // simultaneous push and pop overwrites the top
      step(1'b1, 1'b0, 16'h0033);
      step(1'b1, 1'b1, 16'h0055);
      chk("pp_count", 32'(count), 2);
      chk("pp_dout", 32'(dout), 32'h0055);

      // overflow with transfers disabled
      do_reset();
      en = 1'b0;
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'h00B0 + 16'(i));
      chk("of_count4", 32'(count), 4);
      chk("of_ovf0", 32'(ovf), 0);
      step(1'b1, 1'b0, 16'h00B5);
      chk("of_ovf", 32'(ovf), 1);
      chk("of_count", 32'(count), 4);
      chk("of_dout", 32'(dout), 32'h00B4);

      // underflow
      do_reset();
      step(1'b0, 1'b1, '0);
      chk("uf_unf", 32'(unf), 1);
      chk("uf_count", 32'(count), 0);

      // push and pop held high across transfers
      do_reset();
      en = 1'b1; base_we = 1'b1; base_in = 16'h2000;
      step(1'b0, 1'b0, '0);
      base_we = 1'b0;
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 16'h00C0 + 16'(i));
      wait_idle(20);
      for (int i = 0; i < 14; i++) step(1'b0, 1'b1, '0);
      wait_idle(20);
      step(1'b0, 1'b0, '0);

      // reset in the middle of a spill; a late acknowledge must be ignored
      do_reset();
      auto_ack = 0; mack = 1'b0; en = 1'b1;
      step(1'b1, 1'b0, 16'h00D1);
      step(1'b1, 1'b0, 16'h00D2);
      step(1'b1, 1'b0, 16'h00D3);
      chk("rs_mreq_on", 32'(mreq), 1);
      step(1'b0, 1'b0, '0);
      do_reset();
      chk("rs_mreq", 32'(mreq), 0);
      chk("rs_count", 32'(count), 0);
      chk("rs_mcount", 32'(mcount), 0);
      mack = 1'b1; mdin = 16'hBEEF;
      step(1'b0, 1'b0, '0);
      mack = 1'b0;
      chk("late_count", 32'(count), 0);
      chk("late_mcount", 32'(mcount), 0);
      chk("late_stall", 32'(stall), 0);
      step(1'b0, 1'b0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
